// File: rtl/game_screen_sequencer.sv
// Game screen state owner: join registration, race start, winner latch and return to JOIN.
// Optional start countdown (3,2,1) enabled by defining GAME_COUNTDOWN_EN.
module game_screen_sequencer #(
  parameter int NUM_PLAYERS            = 4,
  parameter int JOIN_TIMEOUT_CLK_COUNT = 1,
  parameter int COUNTDOWN_CLK_COUNT    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_PLAYERS-1:0] player_buttons,
  input  logic [NUM_PLAYERS-1:0] player_finished,
  input  logic                   trigger_reset_all,
  output logic [1:0]             current_screen,
  output logic [NUM_PLAYERS-1:0] joined,
  output logic                   race_enable,
  output logic [NUM_PLAYERS-1:0] winner,
  output logic [1:0]             countdown_value
);

  typedef enum logic [1:0] {
    SCR_JOIN    = 2'b00,
    SCR_PLAYING = 2'b01,
    SCR_END     = 2'b10
  } screen_e;

  localparam int TW = (JOIN_TIMEOUT_CLK_COUNT > 1) ? $clog2(JOIN_TIMEOUT_CLK_COUNT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(JOIN_TIMEOUT_CLK_COUNT - 1);
  localparam logic [NUM_PLAYERS-1:0] ALL_JOINED = {NUM_PLAYERS{1'b1}};

  screen_e                state_r;
  logic [TW-1:0]          timer_r;
  logic [NUM_PLAYERS-1:0] prev_r;
  logic [NUM_PLAYERS-1:0] press_s;
  logic [NUM_PLAYERS-1:0] joined_nxt_s;
  logic [NUM_PLAYERS-1:0] finish_s;
  logic                   start_s;

  function automatic logic [NUM_PLAYERS-1:0] lowest_one(input logic [NUM_PLAYERS-1:0] v);
    lowest_one = v & (~v + NUM_PLAYERS'(1));
  endfunction

  // Full mask is judged on the mask being written this cycle so start lands with the last join.
  always_comb begin
    press_s      = player_buttons & ~prev_r;
    joined_nxt_s = joined | press_s;
    finish_s     = player_finished & joined;
    if (joined_nxt_s == ALL_JOINED) begin
      start_s = 1'b1;
    end else if ((joined != '0) && (timer_r == TIMER_LAST)) begin
      start_s = 1'b1;
    end else begin
      start_s = 1'b0;
    end
  end

  assign current_screen = state_r;

`ifdef GAME_COUNTDOWN_EN
  localparam int SW = (COUNTDOWN_CLK_COUNT > 1) ? $clog2(COUNTDOWN_CLK_COUNT) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(COUNTDOWN_CLK_COUNT - 1);
  logic          counting_r;
  logic [SW-1:0] step_r;
`else
  assign countdown_value = 2'b00;
`endif

  // Screen FSM with all registered outputs and button history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= SCR_JOIN;
      joined      <= '0;
      race_enable <= 1'b0;
      winner      <= '0;
      timer_r     <= '0;
      prev_r      <= '1;
`ifdef GAME_COUNTDOWN_EN
      counting_r      <= 1'b0;
      step_r          <= '0;
      countdown_value <= 2'b00;
`endif
    end else begin
      prev_r <= player_buttons;
      case (state_r)
        SCR_JOIN: begin
`ifdef GAME_COUNTDOWN_EN
          if (counting_r) begin
            if (step_r == STEP_LAST) begin
              step_r <= '0;
              if (countdown_value == 2'd1) begin
                countdown_value <= 2'd0;
                counting_r      <= 1'b0;
                state_r         <= SCR_PLAYING;
                race_enable     <= 1'b1;
              end else begin
                countdown_value <= countdown_value - 2'd1;
              end
            end else begin
              step_r <= step_r + SW'(1);
            end
          end else if (start_s) begin
            joined          <= joined_nxt_s;
            counting_r      <= 1'b1;
            step_r          <= '0;
            countdown_value <= 2'd3;
          end else begin
            joined <= joined_nxt_s;
            if (joined != '0) begin
              timer_r <= timer_r + TW'(1);
            end
          end
`else
          joined <= joined_nxt_s;
          if (start_s) begin
            state_r     <= SCR_PLAYING;
            race_enable <= 1'b1;
          end else if (joined != '0) begin
            timer_r <= timer_r + TW'(1);
          end
`endif
        end
        SCR_PLAYING: begin
          if (finish_s != '0) begin
            winner      <= lowest_one(finish_s);
            state_r     <= SCR_END;
            race_enable <= 1'b0;
          end
        end
        SCR_END: begin
          if (trigger_reset_all) begin
            state_r <= SCR_JOIN;
            joined  <= '0;
            winner  <= '0;
            timer_r <= '0;
          end
        end
        default: begin
          state_r     <= SCR_JOIN;
          joined      <= '0;
          race_enable <= 1'b0;
          winner      <= '0;
          timer_r     <= '0;
`ifdef GAME_COUNTDOWN_EN
          counting_r      <= 1'b0;
          step_r          <= '0;
          countdown_value <= 2'b00;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_screen_sequencer.sv
// Directed bench for game_screen_sequencer (NUM_PLAYERS=4, timeout 10, countdown step 4).
module tb_game_screen_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] player_buttons;
  logic [3:0] player_finished;
  logic       trigger_reset_all;
  logic [1:0] current_screen;
  logic [3:0] joined;
  logic       race_enable;
  logic [3:0] winner;
  logic [1:0] countdown_value;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [3:0] btn;
    logic [3:0] fin;
    logic       trig;
    logic [1:0] scr;
    logic [3:0] jn;
    logic       race;
    logic [3:0] win;
  } vec_t;

  vec_t vecs[$];

  game_screen_sequencer #(
    .NUM_PLAYERS(4),
    .JOIN_TIMEOUT_CLK_COUNT(10),
    .COUNTDOWN_CLK_COUNT(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .player_buttons(player_buttons),
    .player_finished(player_finished),
    .trigger_reset_all(trigger_reset_all),
    .current_screen(current_screen),
    .joined(joined),
    .race_enable(race_enable),
    .winner(winner),
    .countdown_value(countdown_value)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      passes++;
    end
  endtask

  task automatic add(input logic [3:0] btn, input logic [3:0] fin, input logic trig,
                     input logic [1:0] scr, input logic [3:0] jn, input logic race,
                     input logic [3:0] win);
    vec_t v;
    v.btn = btn; v.fin = fin; v.trig = trig;
    v.scr = scr; v.jn = jn; v.race = race; v.win = win;
    vecs.push_back(v);
  endtask

  task automatic chk_all(input string tag, input logic [1:0] scr, input logic [3:0] jn,
                         input logic race, input logic [3:0] win, input logic [1:0] cd);
    chk({tag, " screen"}, 32'(current_screen), 32'(scr));
    chk({tag, " joined"}, 32'(joined), 32'(jn));
    chk({tag, " race_enable"}, 32'(race_enable), 32'(race));
    chk({tag, " winner"}, 32'(winner), 32'(win));
    chk({tag, " countdown"}, 32'(countdown_value), 32'(cd));
  endtask

  task automatic step(input logic [3:0] btn, input logic [3:0] fin, input logic trig);
    player_buttons    = btn;
    player_finished   = fin;
    trigger_reset_all = trig;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // btn2 held through reset; its history bit is all ones so it must not join
    add(4'b0100, 4'b0000, 1'b0, 2'b00, 4'b0000, 1'b0, 4'b0000);
    add(4'b0100, 4'b0000, 1'b0, 2'b00, 4'b0000, 1'b0, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 2'b00, 4'b0000, 1'b0, 4'b0000);
    add(4'b0100, 4'b0000, 1'b0, 2'b00, 4'b0100, 1'b0, 4'b0000);
    add(4'b0100, 4'b0000, 1'b0, 2'b00, 4'b0100, 1'b0, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 2'b00, 4'b0100, 1'b0, 4'b0000);
    add(4'b0100, 4'b0000, 1'b0, 2'b00, 4'b0100, 1'b0, 4'b0000);
    for (int i = 0; i < 6; i++) add(4'b0000, 4'b0000, 1'b0, 2'b00, 4'b0100, 1'b0, 4'b0000);
    // timeout start: 10 cycles after joined became 0100
    add(4'b0000, 4'b0000, 1'b0, 2'b01, 4'b0100, 1'b1, 4'b0000);
    add(4'b0000, 4'b1011, 1'b0, 2'b01, 4'b0100, 1'b1, 4'b0000);
    add(4'b0000, 4'b0000, 1'b1, 2'b01, 4'b0100, 1'b1, 4'b0000);
    add(4'b0001, 4'b0000, 1'b0, 2'b01, 4'b0100, 1'b1, 4'b0000);
    add(4'b0001, 4'b0100, 1'b0, 2'b10, 4'b0100, 1'b0, 4'b0100);
    // END: presses ignored, reset pulse clears, held buttons do not join
    add(4'b0011, 4'b0000, 1'b0, 2'b10, 4'b0100, 1'b0, 4'b0100);
    add(4'b0011, 4'b0000, 1'b1, 2'b00, 4'b0000, 1'b0, 4'b0000);
    add(4'b0011, 4'b0000, 1'b0, 2'b00, 4'b0000, 1'b0, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 2'b00, 4'b0000, 1'b0, 4'b0000);
    // consecutive joins: full mask starts together with the last join
    add(4'b0001, 4'b0000, 1'b0, 2'b00, 4'b0001, 1'b0, 4'b0000);
    add(4'b0010, 4'b0000, 1'b0, 2'b00, 4'b0011, 1'b0, 4'b0000);
    add(4'b0100, 4'b0000, 1'b0, 2'b00, 4'b0111, 1'b0, 4'b0000);
    add(4'b1000, 4'b0000, 1'b0, 2'b01, 4'b1111, 1'b1, 4'b0000);
    add(4'b0000, 4'b1100, 1'b0, 2'b10, 4'b1111, 1'b0, 4'b0100);
    add(4'b0000, 4'b0000, 1'b0, 2'b10, 4'b1111, 1'b0, 4'b0100);
    add(4'b0000, 4'b0000, 1'b1, 2'b00, 4'b0000, 1'b0, 4'b0000);
    // joined=0110 via timeout, then non-joined flags ignored, lowest finisher wins
    add(4'b0010, 4'b0000, 1'b0, 2'b00, 4'b0010, 1'b0, 4'b0000);
    add(4'b0100, 4'b0000, 1'b0, 2'b00, 4'b0110, 1'b0, 4'b0000);
    for (int i = 0; i < 8; i++) add(4'b0000, 4'b0000, 1'b0, 2'b00, 4'b0110, 1'b0, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 2'b01, 4'b0110, 1'b1, 4'b0000);
    add(4'b0000, 4'b1001, 1'b0, 2'b01, 4'b0110, 1'b1, 4'b0000);
    add(4'b0000, 4'b0110, 1'b0, 2'b10, 4'b0110, 1'b0, 4'b0010);
    add(4'b0000, 4'b0000, 1'b1, 2'b00, 4'b0000, 1'b0, 4'b0000);
    // mask completes on the same edge the timeout fires: one start only
    add(4'b0011, 4'b0000, 1'b0, 2'b00, 4'b0011, 1'b0, 4'b0000);
    add(4'b0100, 4'b0000, 1'b0, 2'b00, 4'b0111, 1'b0, 4'b0000);
    for (int i = 0; i < 8; i++) add(4'b0000, 4'b0000, 1'b0, 2'b00, 4'b0111, 1'b0, 4'b0000);
    add(4'b1000, 4'b0000, 1'b0, 2'b01, 4'b1111, 1'b1, 4'b0000);
    add(4'b1000, 4'b0000, 1'b0, 2'b01, 4'b1111, 1'b1, 4'b0000);
    add(4'b0000, 4'b1001, 1'b0, 2'b10, 4'b1111, 1'b0, 4'b0001);
    add(4'b0000, 4'b0000, 1'b1, 2'b00, 4'b0000, 1'b0, 4'b0000);

    rst_n             = 1'b0;
    player_buttons    = 4'b0100;
    player_finished   = 4'b0000;
    trigger_reset_all = 1'b0;
    #12;
    chk_all("reset", 2'b00, 4'b0000, 1'b0, 4'b0000, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

`ifndef GAME_COUNTDOWN_EN
    foreach (vecs[i]) begin
      step(vecs[i].btn, vecs[i].fin, vecs[i].trig);
      chk_all($sformatf("row%0d", i), vecs[i].scr, vecs[i].jn, vecs[i].race,
              vecs[i].win, 2'b00);
    end
    step(4'b1111, 4'b0000, 1'b0);
    chk_all("all_at_once", 2'b01, 4'b1111, 1'b1, 4'b0000, 2'b00);
`else
    // countdown: 3,2,1 for 4 cycles each, trigger and presses ignored meanwhile
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b1111, 4'b0000, 1'b0);
    chk_all("cd0", 2'b00, 4'b1111, 1'b0, 4'b0000, 2'd3);
    for (int k = 1; k < 12; k++) begin
      step(4'b0000, 4'b0000, (k == 5) ? 1'b1 : 1'b0);
      chk_all($sformatf("cd%0d", k), 2'b00, 4'b1111, 1'b0, 4'b0000, 2'(3 - k / 4));
    end
    step(4'b0000, 4'b0000, 1'b0);
    chk_all("cd_done", 2'b01, 4'b1111, 1'b1, 4'b0000, 2'd0);
`endif

    // asynchronous reset mid-PLAYING, sampled well before the next edge
    player_buttons = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 2'b00, 4'b0000, 1'b0, 4'b0000, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0000, 4'b0000, 1'b0);
    chk_all("post_reset", 2'b00, 4'b0000, 1'b0, 4'b0000, 2'b00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
